bus_phase_ctrl: RTL

- Parametrised two-phase external bus controller between a CPU core and the chip's bidirectional pad ring.
- Generates PH1/PH2 phase clocks from the single core clock using a programmable phase length.
- Sequences address, R/W and data-pad direction per bus cycle, with RDY stretching and AEC bus release.
- Successor to the fixed-width 6502 pad hookup: adds parametrised width and phase length, write turnaround, and explicit pad output enables.

---
 rtl/bus_phase_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bus_phase_ctrl.sv
// Two-phase external bus controller: derives PH1/PH2 from the core clock and
// sequences address, R/W and data-pad direction with RDY stretching and AEC release.
module bus_phase_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 4,
    parameter int TURN    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] phase_len,
    input  logic               core_req,
    input  logic [ADDR_W-1:0]  core_addr,
    input  logic               core_rw_n,
    input  logic [DATA_W-1:0]  core_wdata,
    output logic               core_done,
    output logic [DATA_W-1:0]  core_rdata,
    output logic               ph1,
    output logic               ph2,
    input  logic               rdy,
    input  logic               aec,
    output logic [ADDR_W-1:0]  pad_addr,
    output logic               pad_rw_n,
    output logic               pad_ctl_oe,
    output logic [DATA_W-1:0]  pad_dout,
    output logic               pad_doe,
    input  logic [DATA_W-1:0]  pad_din
);

    typedef enum logic [1:0] {IDLE, P1, P2} state_t;

    localparam logic [PHASE_W-1:0] TURN_C = PHASE_W'(TURN);
    localparam logic [PHASE_W-1:0] ONE    = PHASE_W'(1);

    state_t             state, state_nx;
    logic [PHASE_W-1:0] cnt, cnt_nx, len, len_nx, req_len;
    logic [ADDR_W-1:0]  addr_nx;
    logic               rw_nx, doe_nx, done_nx, last, take;
    logic [DATA_W-1:0]  dout_nx, rdata_nx;

    assign ph2     = (state == P2);
    assign ph1     = ~ph2;
    assign last    = (cnt == len - ONE);
    assign req_len = (phase_len == '0) ? ONE : phase_len;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        len_nx   = len;
        addr_nx  = pad_addr;
        rw_nx    = pad_rw_n;
        dout_nx  = pad_dout;
        rdata_nx = core_rdata;
        done_nx  = 1'b0;
        take     = 1'b0;
        case (state)
            IDLE: take = core_req;
            P1: begin
                if (last) begin
                    state_nx = P2;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            P2: begin
                if (last) begin
                    cnt_nx = '0;
                    if (pad_rw_n && !rdy) begin
                        state_nx = P1;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                        take     = core_req;
                        if (pad_rw_n)
                            rdata_nx = pad_din;
                    end
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A completing cycle may capture the next request on the same edge.
        if (take) begin
            addr_nx  = core_addr;
            rw_nx    = core_rw_n;
            dout_nx  = core_wdata;
            len_nx   = req_len;
            cnt_nx   = '0;
            state_nx = P1;
        end
        doe_nx = aec && !pad_rw_n && (state_nx == P2) && (cnt_nx >= TURN_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            len        <= '0;
            pad_addr   <= '0;
            pad_rw_n   <= 1'b1;
            pad_ctl_oe <= 1'b0;
            pad_dout   <= '0;
            pad_doe    <= 1'b0;
            core_done  <= 1'b0;
            core_rdata <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            len        <= len_nx;
            pad_addr   <= addr_nx;
            pad_rw_n   <= rw_nx;
            pad_ctl_oe <= aec;
            pad_dout   <= dout_nx;
            pad_doe    <= doe_nx;
            core_done  <= done_nx;
            core_rdata <= rdata_nx;
        end
    end

endmodule
